// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared FSM state encoding and index-width helper for reg_share_arbiter
package reg_share_pkg;

  // Arbiter FSM states; encodings are fixed so state can be decoded externally if needed
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Ceiling log2, used to size requester index fields (n >= 2 assumed)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
import reg_share_pkg::*;

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan rr_last+1, rr_last+2, ... (mod N_REQ); the first set request wins
  always_comb begin
    int cand;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_last) + k) % N_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        index        = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin sharing of one holding register between requesters
import reg_share_pkg::*;

module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qb,
  output logic                   q_valid,
  output logic [IDX_W-1:0]       q_owner,
  input  logic                   rd_ack,
  output logic                   busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_last_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [WIDTH-1:0]   q_q;
  logic               q_valid_q;
  logic [IDX_W-1:0]   q_owner_q;

  logic               arb_en;
  logic               capture;
  logic               release_q;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_index;
  logic               pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .onehot  (pick_onehot),
    .index   (pick_index),
    .any     (pick_any)
  );

  // FSM state register; reset discards any transfer in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and datapath strobes; rd_ack only matters in HOLD
  always_comb begin
    state_d   = state_q;
    arb_en    = 1'b0;
    capture   = 1'b0;
    release_q = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          arb_en  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (rd_ack) begin
          release_q = 1'b1;
          if (pick_any) begin
            arb_en  = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer and holding register; the winner index doubles as rr_last
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q     <= '0;
      rr_last_q <= IDX_W'(N_REQ - 1);
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_owner_q <= '0;
    end else begin
      if (arb_en) begin
        gnt_q     <= pick_onehot;
        rr_last_q <= pick_index;
      end else if (capture) begin
        gnt_q     <= '0;
      end
      if (capture) begin
        q_q       <= req_data[int'(rr_last_q)*WIDTH +: WIDTH];
        q_owner_q <= rr_last_q;
        q_valid_q <= 1'b1;
      end else if (release_q) begin
        q_valid_q <= 1'b0;
      end
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign qb      = ~q_q;
  assign q_valid = q_valid_q;
  assign q_owner = q_owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic        q_valid;
  logic [1:0]  q_owner;
  logic        rd_ack;
  logic        busy;

  logic [7:0]  d [4];
  int          n_cmp;
  int          n_err;
  int          m_last;

  reg_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .q        (q),
    .qb       (qb),
    .q_valid  (q_valid),
    .q_owner  (q_owner),
    .rd_ack   (rd_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = d[i];
  end

  // Winner by rule: first set request scanning from last+1 around the ring
  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    m_last = 3;
  endtask

  task automatic test_reset();
    req = 4'hF;
    rd_ack = 1'b0;
    step();
    resetn = 1'b0;
    #2;
    n_cmp++;
    if ({gnt, q, qb, q_valid, busy} !== {4'h0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%h q=%h qb=%h v=%b busy=%b, want 0/00/ff/0/0", gnt, q, qb, q_valid, busy);
    end
    step();
    step();
    req = 4'h0;
    resetn = 1'b1;
    m_last = 3;
  endtask

  task automatic test_single();
    apply_reset();
    d[2] = 8'hA5;
    req = 4'b0100;
    step();
    n_cmp++;
    if ({gnt, busy, q_valid} !== {4'b0100, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_gnt: got gnt=%b busy=%b v=%b, want 0100/1/0", gnt, busy, q_valid);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if ({q, qb, q_owner, q_valid, gnt} !== {8'hA5, 8'h5A, 2'd2, 1'b1, 4'h0}) begin
      n_err++;
      $display("FAIL single_load: got q=%h qb=%h own=%0d v=%b gnt=%b, want a5/5a/2/1/0000", q, qb, q_owner, q_valid, gnt);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    n_cmp++;
    if ({q_valid, busy, q} !== {1'b0, 1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL single_release: got v=%b busy=%b q=%h, want 0/0/a5", q_valid, busy, q);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    apply_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
    req = 4'hF;
    rd_ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      exp = pick(4'hF, m_last);
      step();
      n_cmp++;
      if ({gnt, q_valid} !== {oh(exp), 1'b0}) begin
        n_err++;
        $display("FAIL rr_gnt[%0d]: got gnt=%b v=%b, want %b/0", t, gnt, q_valid, oh(exp));
      end
      m_last = exp;
      if (t == 4) req = 4'h0;
      step();
      n_cmp++;
      if ({q_owner, q, q_valid, gnt} !== {2'(exp), d[exp], 1'b1, 4'h0}) begin
        n_err++;
        $display("FAIL rr_data[%0d]: got own=%0d q=%h v=%b gnt=%b, want %0d/%h/1/0000", t, q_owner, q, q_valid, gnt, exp, d[exp]);
      end
    end
    step();
    rd_ack = 1'b0;
    n_cmp++;
    if ({busy, q_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rr_drain: got busy=%b v=%b, want 0/0", busy, q_valid);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    d[1] = 8'h77;
    req = 4'b0010;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({q, q_valid, gnt, busy} !== {8'h77, 1'b1, 4'h0, 1'b1}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got q=%h v=%b gnt=%b busy=%b, want 77/1/0000/1", c, q, q_valid, gnt, busy);
      end
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    n_cmp++;
    if ({gnt, q_valid} !== {4'b0010, 1'b0}) begin
      n_err++;
      $display("FAIL hold_b2b_gnt: got gnt=%b v=%b, want 0010/0", gnt, q_valid);
    end
    req = 4'b0000;
    d[1] = 8'h78;
    step();
    n_cmp++;
    if ({q, q_owner, q_valid} !== {8'h78, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL hold_b2b_data: got q=%h own=%0d v=%b, want 78/1/1", q, q_owner, q_valid);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    d[0] = 8'h3C;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    n_cmp++;
    if ({q, q_valid} !== {8'h3C, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_pre: got q=%h v=%b, want 3c/1", q, q_valid);
    end
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, q, qb, q_valid, q_owner, busy} !== {4'h0, 8'h00, 8'hFF, 1'b0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_async: got gnt=%b q=%h qb=%h v=%b own=%0d busy=%b, want reset values", gnt, q, qb, q_valid, q_owner, busy);
    end
    step();
    resetn = 1'b1;
    m_last = 3;
    d[3] = 8'hC3;
    req = 4'b1000;
    step();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_first_gnt: got %b, want 1000", gnt);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if ({q, q_owner, q_valid} !== {8'hC3, 2'd3, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_data: got q=%h own=%0d v=%b, want c3/3/1", q, q_owner, q_valid);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
  endtask

  task automatic test_ack_ignored();
    apply_reset();
    rd_ack = 1'b1;
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({busy, q_valid, gnt} !== {1'b0, 1'b0, 4'h0}) begin
        n_err++;
        $display("FAIL ack_idle[%0d]: got busy=%b v=%b gnt=%b, want 0/0/0000", c, busy, q_valid, gnt);
      end
    end
    d[0] = 8'h5E;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    n_cmp++;
    if ({q, q_valid, busy} !== {8'h5E, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ack_load: got q=%h v=%b busy=%b, want 5e/1/1", q, q_valid, busy);
    end
    step();
    rd_ack = 1'b0;
    n_cmp++;
    if ({q_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL ack_release: got v=%b busy=%b, want 0/0", q_valid, busy);
    end
  endtask

  task automatic test_random();
    int exp;
    int waits;
    logic [3:0] r;
    logic [7:0] held;
    logic in_hold;
    apply_reset();
    in_hold = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (in_hold && ($urandom_range(0, 1) == 1)) begin
        held = q;
        rd_ack = 1'b1;
        req = 4'b0000;
        step();
        rd_ack = 1'b0;
        in_hold = 1'b0;
        n_cmp++;
        if ({busy, q_valid, q} !== {1'b0, 1'b0, held}) begin
          n_err++;
          $display("FAIL rand_release[%0d]: got busy=%b v=%b q=%h, want 0/0/%h", t, busy, q_valid, q, held);
        end
      end
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      exp = pick(r, m_last);
      if (in_hold) rd_ack = 1'b1;
      req = r;
      step();
      rd_ack = 1'b0;
      n_cmp++;
      if ({gnt, q_valid} !== {oh(exp), 1'b0}) begin
        n_err++;
        $display("FAIL rand_gnt[%0d]: got gnt=%b v=%b, want %b/0 (req=%b)", t, gnt, q_valid, oh(exp), r);
      end
      m_last = exp;
      req = 4'($urandom);
      step();
      n_cmp++;
      if ({q, qb, q_owner, q_valid, gnt} !== {d[exp], ~d[exp], 2'(exp), 1'b1, 4'h0}) begin
        n_err++;
        $display("FAIL rand_data[%0d]: got q=%h qb=%h own=%0d v=%b gnt=%b, want %h/%h/%0d/1/0000", t, q, qb, q_owner, q_valid, gnt, d[exp], ~d[exp], exp);
      end
      waits = $urandom_range(0, 3);
      for (int c = 0; c < waits; c++) begin
        req = 4'($urandom);
        step();
        n_cmp++;
        if ({q, q_valid, gnt} !== {d[exp], 1'b1, 4'h0}) begin
          n_err++;
          $display("FAIL rand_hold[%0d]: got q=%h v=%b gnt=%b, want %h/1/0000", t, q, q_valid, gnt, d[exp]);
        end
      end
      in_hold = 1'b1;
    end
    rd_ack = 1'b1;
    req = 4'b0000;
    step();
    rd_ack = 1'b0;
    n_cmp++;
    if ({busy, q_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rand_drain: got busy=%b v=%b, want 0/0", busy, q_valid);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_last = 3;
    resetn = 1'b0;
    req    = 4'h0;
    rd_ack = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid_hold();
    test_ack_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
